// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity state controlled by macro UART_TX_PARITY_EN.
package uart_pkg;

  // Transmit FSM states; the parity state exists only when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Register offsets relative to BASE_ADDR.
  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // STATUS word bit positions.
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_COUNT_MSB = 4;
  localparam int ST_OVF_BIT   = 5;

  // Assemble the STATUS word; all unlisted bits read zero.
  function automatic logic [31:0] status_word(input logic ovf, input logic [2:0] cnt,
                                              input logic full, input logic busy);
    logic [31:0] w;
    w = '0;
    w[ST_BUSY_BIT]                = busy;
    w[ST_FULL_BIT]                = full;
    w[ST_COUNT_MSB:ST_COUNT_LSB]  = cnt;
    w[ST_OVF_BIT]                 = ovf;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// Latency: a pushed word is visible at dout on the cycle after the push edge.
// Backpressure: push to a full FIFO is dropped unless a pop occurs on the same edge.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A pop on the same edge frees a slot, so a push to a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Extra MSB on each pointer separates the full and empty cases.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA push port, STATUS read port, 8N1 (or 8E1 with UART_TX_PARITY_EN).
// Latency: byte stored on edge E into an idle, empty block drives the start bit after edge E+1.
// Backpressure: stores to a full FIFO are dropped and set the sticky overflow flag; frames run back-to-back.
module mmio_uart_tx import uart_pkg::*; #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;

  state_t         state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           overflow;
  logic           baud_wrap;
  logic           wr_txdata;
  logic           wr_status;
  logic           pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           unused_wdata;
`ifdef UART_TX_PARITY_EN
  logic           parity_bit;
`endif

  assign unused_wdata = ^WriteData[31:8];

  assign wr_txdata = MemWrite && (DataAdr == BASE_ADDR + TXDATA_OFS);
  assign wr_status = MemWrite && (DataAdr == BASE_ADDR + STATUS_OFS);
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Pop when idle, or at the last cycle of a stop bit so the next frame follows without a gap.
  assign pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_wrap));

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: set by a dropped store, cleared by any store to STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_txdata && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (wr_status) begin
      overflow <= 1'b0;
    end
  end

  // Transmit FSM with baud counter, bit index, shift register and registered tx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state != ST_IDLE) baud_cnt <= baud_wrap ? '0 : baud_cnt + BW'(1);
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg <= fifo_dout;
            tx    <= 1'b0;
            state <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity_bit;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_wrap) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_wrap) begin
            if (pop) begin
              shreg <= fifo_dout;
              tx    <= 1'b0;
              state <= ST_START;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_dout;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // STATUS is decoded combinationally; TXDATA and unmapped addresses read zero.
  always_comb begin
    ReadData = '0;
    if (DataAdr == BASE_ADDR + STATUS_OFS)
      ReadData = status_word(overflow, 3'(fifo_count), fifo_full, state != ST_IDLE);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: serial decoder checks bytes against a scoreboard queue.
// Latency: checks first-start timing, frame lengths and back-to-back spacing.
// Backpressure: exercises FIFO overflow and its clear via STATUS.
module tb_mmio_uart_tx;

  localparam int          C    = 16;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] STAT = 32'h0000_0404;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sb[$];
  int         starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serial decoder: samples mid-bit, compares the byte with the scoreboard head at the stop bit.
  bit         mon_on = 1'b0;
  int         mon_cnt;
  logic [7:0] rx;
  logic       rx_par;
  always @(negedge clk) begin : mon
    int         k;
    logic [7:0] exp_b;
    if (reset) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx == 1'b0) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == C / 2) begin
        k = mon_cnt / C;
        if (k == 0) begin
          chk("start_bit", 32'(tx), 32'd0);
        end else if (k <= 8) begin
          rx[k-1] = tx;
        end else if (k == NBITS - 1) begin
          chk("stop_bit", 32'(tx), 32'd1);
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            chk("rx_byte", 32'(rx), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(rx_par), 32'(^exp_b));
`endif
          end
        end else begin
          rx_par = tx;
        end
      end
      if (mon_cnt == FRAME - 1) mon_on = 1'b0;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr(BASE, {24'h0, b});
    sb.push_back(b);
  endtask

  task automatic idle();
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = STAT;
    WriteData = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    DataAdr = a;
    #1;
    v = ReadData;
    DataAdr = STAT;
  endtask

  // Counts negedges until busy=0 and FIFO empty, bounded by budget.
  task automatic wait_drain(input string tag, input int budget, output int n);
    logic [31:0] v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rd(STAT, v);
    end while (!(v[0] == 1'b0 && v[4:2] == 3'd0) && n < budget);
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          n;
    int          lows;

    reset = 1'b1; MemWrite = 1'b0; DataAdr = STAT; WriteData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    rd(STAT, v);  chk("reset_status", v, 32'h0);
    rd(BASE, v);  chk("txdata_reads_zero", v, 32'h0);

    // Single frame: latency and length.
    wr_byte(8'h55);
    idle();
    chk("lat_edge_e_tx", 32'(tx), 32'd1);
    rd(STAT, v);  chk("lat_edge_e_status", v, 32'h0000_0004);
    @(negedge clk);
    chk("lat_edge_e1_tx", 32'(tx), 32'd0);
    rd(STAT, v);  chk("lat_edge_e1_status", v, 32'h0000_0001);
    wait_drain("drain_55", FRAME + 40, n);
    chk("frame_len_55", 32'(n), 32'(FRAME));
    chk("sb_empty_55", 32'(sb.size()), 32'd0);

    // Overflow: 5 accepted (first pops at E+1), 6th dropped.
    for (int i = 1; i <= 5; i++) wr_byte(8'(i));
    wr(BASE, 32'h0000_0006);
    idle();
    rd(STAT, v);  chk("overflow_status", v, 32'h0000_0033);
    wr(STAT, 32'h0);
    idle();
    rd(STAT, v);  chk("overflow_cleared", v, 32'h0000_0013);
    wait_drain("drain_ovf", 5 * FRAME + 40, n);
    chk("sb_empty_ovf", 32'(sb.size()), 32'd0);

    // Back-to-back frames.
    starts.delete();
    wr_byte(8'hA5);
    wr_byte(8'h3C);
    idle();
    wait_drain("drain_b2b", 2 * FRAME + 40, n);
    chk("two_frame_len", 32'(n), 32'(2 * FRAME));
    chk("b2b_frames", 32'(starts.size()), 32'd2);
    if (starts.size() >= 2) chk("b2b_spacing", 32'(starts[1] - starts[0]), 32'(FRAME));
    chk("sb_empty_b2b", 32'(sb.size()), 32'd0);

    // Reset mid-frame aborts and discards queued bytes.
    wr_byte(8'h5A);
    wr_byte(8'hC3);
    idle();
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("abort_start_seen", 32'(n < 10), 32'd1);
    repeat (69) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx_high", 32'(tx), 32'd1);
    rd(STAT, v);  chk("abort_status", v, 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    chk("no_frame_after_reset", 32'(lows), 32'd0);

    // Unmapped stores do nothing and read zero.
    wr(BASE + 32'd8, 32'h77);
    wr(32'h0000_0060, 32'h88);
    idle();
    rd(BASE + 32'd8, v); chk("unmapped_8_read", v, 32'h0);
    rd(32'h60, v);       chk("unmapped_60_read", v, 32'h0);
    rd(STAT, v);         chk("unmapped_no_push", v, 32'h0);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    chk("unmapped_tx_idle", 32'(lows), 32'd0);

    // Odd-weight byte: frame length and parity bit when enabled.
    wr_byte(8'h07);
    idle();
    @(negedge clk);
    wait_drain("drain_07", FRAME + 40, n);
    chk("frame_len_07", 32'(n), 32'(FRAME));
    chk("sb_empty_07", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
